// File: rtl/fpro_bus_bridge.sv
// Avalon-MM slave to FPro bus bridge.
// The top address bits select one of N_CS one-hot chip-select regions.
// FPro strobes are one cycle wide, and every fp_* output is registered.
// Reads wait READ_LAT cycles for the slave data before the bridge responds.
// An access to a region with no chip select completes with the normal timing.
// It returns UNMAPPED_DATA and raises the err_unmapped pulse.
module fpro_bus_bridge #(
  parameter int                FP_ADDR_W     = 21,
  parameter int                DATA_W        = 32,
  parameter int                N_CS          = 2,
  parameter int                READ_LAT      = 0,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = 32'hDEAD_BEEF,
  localparam int               SEL_W         = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic [FP_ADDR_W+SEL_W-1:0] av_address,
  input  logic                       av_read,
  input  logic                       av_write,
  input  logic [DATA_W-1:0]          av_writedata,
  output logic [DATA_W-1:0]          av_readdata,
  output logic                       av_waitrequest,
  output logic [FP_ADDR_W-1:0]       fp_address,
  output logic [DATA_W-1:0]          fp_writedata,
  input  logic [DATA_W-1:0]          fp_readdata,
  output logic                       fp_write,
  output logic                       fp_read,
  output logic [N_CS-1:0]            fp_cs,
  output logic                       err_unmapped
);

  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RESP} state_t;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic             unmapped_q;

  logic [SEL_W-1:0] sel;
  logic             mapped;
  logic [N_CS-1:0]  cs_dec;

  // Decode the region from the live request; the result is used only in IDLE.
  assign sel    = av_address[FP_ADDR_W+SEL_W-1:FP_ADDR_W];
  assign mapped = ({1'b0, sel} < (SEL_W+1)'(N_CS));
  assign cs_dec = mapped ? (N_CS'(1) << sel) : '0;

  // The master is released only in the single completion cycle of each transfer.
  assign av_waitrequest = !((state == WR) || (state == RESP));

  // Transfer sequencer. The strobes and the error pulse default low, so each lasts one cycle.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      unmapped_q   <= 1'b0;
      fp_write     <= 1'b0;
      fp_read      <= 1'b0;
      fp_cs        <= '0;
      fp_address   <= '0;
      fp_writedata <= '0;
      av_readdata  <= '0;
      err_unmapped <= 1'b0;
    end else begin
      fp_write     <= 1'b0;
      fp_read      <= 1'b0;
      err_unmapped <= 1'b0;
      case (state)
        IDLE: begin
          // A write takes priority when the master asserts write and read together.
          if (av_write) begin
            fp_address   <= av_address[FP_ADDR_W-1:0];
            fp_writedata <= av_writedata;
            fp_cs        <= cs_dec;
            fp_write     <= mapped;
            unmapped_q   <= !mapped;
            err_unmapped <= !mapped;
            state        <= WR;
          end else if (av_read) begin
            fp_address <= av_address[FP_ADDR_W-1:0];
            fp_cs      <= cs_dec;
            fp_read    <= mapped;
            unmapped_q <= !mapped;
            state      <= RD;
          end
        end
        WR: begin
          fp_cs <= '0;
          state <= IDLE;
        end
        RD: begin
          if (READ_LAT == 0) begin
            // With no slave latency, the data is valid in the same cycle as fp_read.
            av_readdata  <= unmapped_q ? UNMAPPED_DATA : fp_readdata;
            err_unmapped <= unmapped_q;
            fp_cs        <= '0;
            state        <= RESP;
          end else begin
            lat_cnt <= LAT_W'(READ_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          // fp_cs and fp_address stay stable until the slave data is captured.
          if (lat_cnt == '0) begin
            av_readdata  <= unmapped_q ? UNMAPPED_DATA : fp_readdata;
            err_unmapped <= unmapped_q;
            fp_cs        <= '0;
            state        <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpro_bus_bridge.sv
// Testbench for fpro_bus_bridge with two instances.
// Instance A uses two regions and a zero-latency slave.
// Instance B uses three regions (sel 3 unmapped) and a three-cycle slave latency.
// Slave read data ramps by one every cycle, so the check also pins the capture cycle.
module tb_fpro_bus_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A: N_CS=2, READ_LAT=0
  logic [21:0] addr_a = '0;
  logic        rd_a = 1'b0, wr_a = 1'b0;
  logic [31:0] wd_a = '0, slv_a = '0;
  logic [31:0] rdata_a, fwd_a;
  logic        wt_a, fwr_a, frd_a, err_a;
  logic [20:0] fpa_a;
  logic [1:0]  cs_a;

  // instance B: N_CS=3, READ_LAT=3
  logic [22:0] addr_b = '0;
  logic        rd_b = 1'b0, wr_b = 1'b0;
  logic [31:0] wd_b = '0, slv_b = '0;
  logic [31:0] rdata_b, fwd_b;
  logic        wt_b, fwr_b, frd_b, err_b;
  logic [20:0] fpa_b;
  logic [2:0]  cs_b;

  fpro_bus_bridge #(.N_CS(2), .READ_LAT(0)) u_a (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .av_address(addr_a), .av_read(rd_a), .av_write(wr_a), .av_writedata(wd_a),
    .av_readdata(rdata_a), .av_waitrequest(wt_a),
    .fp_address(fpa_a), .fp_writedata(fwd_a), .fp_readdata(slv_a),
    .fp_write(fwr_a), .fp_read(frd_a), .fp_cs(cs_a), .err_unmapped(err_a)
  );

  fpro_bus_bridge #(.N_CS(3), .READ_LAT(3)) u_b (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .av_address(addr_b), .av_read(rd_b), .av_write(wr_b), .av_writedata(wd_b),
    .av_readdata(rdata_b), .av_waitrequest(wt_b),
    .fp_address(fpa_b), .fp_writedata(fwd_b), .fp_readdata(slv_b),
    .fp_write(fwr_b), .fp_read(frd_b), .fp_cs(cs_b), .err_unmapped(err_b)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        wt;
    logic [20:0] fpa;
    logic [31:0] fwd;
    logic        fwr;
    logic        frd;
    logic [2:0]  cs;
    logic        err;
  } obs_t;

  typedef struct {
    int          d;
    logic        wr;
    logic        both;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [31:0] slave;
    logic [2:0]  e_cs;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat;
    int          e_wstb;
    int          e_rstb;
    int          e_cscyc;
  } vec_t;

  int   errs = 0;
  int   n_chk = 0;
  vec_t exp_q[$];
  vec_t vecs[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic obs_t sample(int d);
    obs_t o;
    if (d == 0) begin
      o.rdata = rdata_a;
      o.wt = wt_a;
      o.fpa = fpa_a;
      o.fwd = fwd_a;
      o.fwr = fwr_a;
      o.frd = frd_a;
      o.cs = {1'b0, cs_a};
      o.err = err_a;
    end else begin
      o.rdata = rdata_b;
      o.wt = wt_b;
      o.fpa = fpa_b;
      o.fwd = fwd_b;
      o.fwr = fwr_b;
      o.frd = frd_b;
      o.cs = cs_b;
      o.err = err_b;
    end
    return o;
  endfunction

  task automatic drive(int d, logic rd, logic wr, logic [22:0] addr, logic [31:0] wd);
    if (d == 0) begin
      rd_a = rd;
      wr_a = wr;
      addr_a = addr[21:0];
      wd_a = wd;
    end else begin
      rd_b = rd;
      wr_b = wr;
      addr_b = addr;
      wd_b = wd;
    end
  endtask

  task automatic set_slave(int d, logic [31:0] v);
    if (d == 0) slv_a = v;
    else        slv_b = v;
  endtask

  task automatic check_reset_state(int d, string tag);
    obs_t o;
    o = sample(d);
    chk({tag, "_wait"}, 32'(o.wt), 32'd1);
    chk({tag, "_cs"}, 32'(o.cs), 32'd0);
    chk({tag, "_strobes"}, 32'({o.fwr, o.frd}), 32'd0);
    chk({tag, "_fpa"}, 32'(o.fpa), 32'd0);
    chk({tag, "_fwd"}, o.fwd, 32'd0);
    chk({tag, "_rdata"}, o.rdata, 32'd0);
    chk({tag, "_err"}, 32'(o.err), 32'd0);
  endtask

  // Issue one request, hold it until waitrequest drops, then score it against the queued expectation.
  task automatic run_vec(vec_t v);
    obs_t        o;
    vec_t        e;
    int          lat = 0, wstb = 0, rstb = 0, cscyc = 0;
    logic [2:0]  cs_or = '0;
    logic        err_seen = 1'b0;
    logic [31:0] rd_data = '0;
    logic [20:0] fpa_end = '0;
    logic [31:0] fwd_end = '0;
    exp_q.push_back(v);
    drive(v.d, !v.wr || v.both, v.wr, v.addr, v.wdata);
    set_slave(v.d, v.slave);
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(posedge clk); #1;
      o = sample(v.d);
      set_slave(v.d, v.slave + 32'(k));
      wstb += int'(o.fwr);
      rstb += int'(o.frd);
      if (o.cs != '0) cscyc++;
      cs_or |= o.cs;
      err_seen |= o.err;
      if (!o.wt) begin
        lat = k;
        rd_data = o.rdata;
        fpa_end = o.fpa;
        fwd_end = o.fwd;
        drive(v.d, 1'b0, 1'b0, v.addr, v.wdata);
      end
    end
    if (lat == 0) drive(v.d, 1'b0, 1'b0, v.addr, v.wdata);
    e = exp_q.pop_front();
    chk($sformatf("v%0h_latency", e.addr), 32'(lat), 32'(e.e_lat));
    chk($sformatf("v%0h_cs", e.addr), 32'(cs_or), 32'(e.e_cs));
    chk($sformatf("v%0h_cs_cycles", e.addr), 32'(cscyc), 32'(e.e_cscyc));
    chk($sformatf("v%0h_wr_strobes", e.addr), 32'(wstb), 32'(e.e_wstb));
    chk($sformatf("v%0h_rd_strobes", e.addr), 32'(rstb), 32'(e.e_rstb));
    chk($sformatf("v%0h_err", e.addr), 32'(err_seen), 32'(e.e_err));
    chk($sformatf("v%0h_fp_address", e.addr), 32'(fpa_end), 32'(e.addr[20:0]));
    if (e.wr) chk($sformatf("v%0h_fp_writedata", e.addr), fwd_end, e.wdata);
    else      chk($sformatf("v%0h_readdata", e.addr), rd_data, e.e_rdata);
    @(posedge clk); #1;
    o = sample(v.d);
    chk($sformatf("v%0h_after_wait", e.addr), 32'(o.wt), 32'd1);
    chk($sformatf("v%0h_after_cs", e.addr), 32'(o.cs), 32'd0);
    chk($sformatf("v%0h_after_err", e.addr), 32'(o.err), 32'd0);
  endtask

  initial begin
    obs_t o;
    int   low_cnt;
    int   rd_cnt;
    //               d wr both addr                      wdata         slave         cs     rdata         err lat w r cyc
    vecs[0] = '{0, 1'b1, 1'b0, {2'b01, 21'h00010}, 32'h1234_5678, 32'h0, 3'b010, 32'h0, 1'b0, 1, 1, 0, 1};
    vecs[1] = '{0, 1'b0, 1'b0, {2'b00, 21'h00005}, 32'h0, 32'hCAFE_0000, 3'b001, 32'hCAFE_0001, 1'b0, 2, 0, 1, 1};
    vecs[2] = '{0, 1'b1, 1'b0, {2'b00, 21'h1FFFFF}, 32'hA5A5_5A5A, 32'h0, 3'b001, 32'h0, 1'b0, 1, 1, 0, 1};
    vecs[3] = '{0, 1'b1, 1'b1, {2'b01, 21'h00022}, 32'h0F0F_F0F0, 32'h0, 3'b010, 32'h0, 1'b0, 1, 1, 0, 1};
    vecs[4] = '{1, 1'b1, 1'b0, {2'd2, 21'h00003}, 32'h8765_4321, 32'h0, 3'b100, 32'h0, 1'b0, 1, 1, 0, 1};
    vecs[5] = '{1, 1'b0, 1'b0, {2'd1, 21'h00077}, 32'h0, 32'h0BAD_F000, 3'b010, 32'h0BAD_F004, 1'b0, 5, 0, 1, 4};
    vecs[6] = '{1, 1'b0, 1'b0, {2'd3, 21'h00009}, 32'h0, 32'h1111_0000, 3'b000, 32'hDEAD_BEEF, 1'b1, 5, 0, 0, 0};
    vecs[7] = '{1, 1'b1, 1'b0, {2'd3, 21'h0000A}, 32'h5555_AAAA, 32'h0, 3'b000, 32'h0, 1'b1, 1, 0, 0, 0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_state(0, "rst_a");
    check_reset_state(1, "rst_b");
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // A held write re-issues every second cycle: WR on odd cycles, IDLE on even cycles.
    drive(0, 1'b0, 1'b1, {2'b01, 21'h00040}, 32'h7777_0001);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      o = sample(0);
      chk($sformatf("b2b_fp_write_c%0d", k), 32'(o.fwr), 32'(k % 2));
      chk($sformatf("b2b_cs_c%0d", k), 32'(o.cs), (k % 2 == 1) ? 32'd2 : 32'd0);
      chk($sformatf("b2b_wait_c%0d", k), 32'(o.wt), 32'(1 - (k % 2)));
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;

    // A reset in WAIT drops the read; no response follows.
    drive(1, 1'b1, 1'b0, {2'd0, 21'h00123}, 32'h0);
    set_slave(1, 32'h4444_4444);
    @(posedge clk); #1;
    o = sample(1);
    chk("rstwait_fp_read_in_rd", 32'(o.frd), 32'd1);
    @(posedge clk); #1;
    o = sample(1);
    chk("rstwait_cs_in_wait", 32'(o.cs), 32'd1);
    rst_n = 1'b0;
    drive(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    check_reset_state(1, "rstwait");
    rst_n = 1'b1;
    low_cnt = 0;
    rd_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      o = sample(1);
      low_cnt += int'(!o.wt);
      rd_cnt += int'(o.frd);
    end
    chk("rstwait_no_resp", 32'(low_cnt), 32'd0);
    chk("rstwait_no_strobe", 32'(rd_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule
